// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the fetch (I) port, the data (D) port, the unified
// memory handshake, and the error flag with its clear.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  logic        stall_f;
  logic        stall_m;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        err;
  logic        err_clr;

  // Arbiter side
  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_rdata, mem_ready, err_clr,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output stall_f, stall_m,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output err
  );

  // Pipeline stages plus memory side
  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_rdata, mem_ready, err_clr,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  stall_f, stall_m,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port unified memory arbiter for the fetch and memory stages, with fetch
// anti-starvation and a sticky timeout error for a memory that never answers.
//
// state  | meaning
// IDLE   | no access in flight; grants are issued combinationally here
// BUSY_I | fetch access in flight, waiting for mem_ready or timeout
// BUSY_D | data access in flight, waiting for mem_ready or timeout
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t          stateQ, stateD;
  logic            iWin, dWin, memDone, tmoHit, starved;
  logic [SW-1:0]   starveCnt;
  logic [TW-1:0]   tmoCnt;
  logic            memReq, memWe;
  logic [31:0]     memAddr, memWdata;
  logic [3:0]      memWstrb;
  logic            iRvalid, dRvalid;
  logic [31:0]     iRdata, dRdata;
  logic            errQ;

  assign starved = (starveCnt == SW'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateQ <= IDLE;
    else      stateQ <= stateD;
  end

  always_comb begin
    stateD  = stateQ;
    iWin    = 1'b0;
    dWin    = 1'b0;
    memDone = 1'b0;
    tmoHit  = 1'b0;
    case (stateQ)
      IDLE: begin
        // D has priority on a contest unless fetch has lost too many in a row
        if (bus.i_req && (!bus.d_req || starved)) begin
          iWin   = 1'b1;
          stateD = BUSY_I;
        end else if (bus.d_req) begin
          dWin   = 1'b1;
          stateD = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ready) begin
          memDone = 1'b1;
          stateD  = IDLE;
        end else if (tmoCnt == TW'(TIMEOUT - 1)) begin
          tmoHit = 1'b1;
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      memWstrb  <= '0;
      iRvalid   <= 1'b0;
      dRvalid   <= 1'b0;
      iRdata    <= '0;
      dRdata    <= '0;
      tmoCnt    <= '0;
      starveCnt <= '0;
      errQ      <= 1'b0;
    end else begin
      iRvalid <= 1'b0;
      dRvalid <= 1'b0;

      if (iWin) begin
        memReq   <= 1'b1;
        memWe    <= 1'b0;
        memAddr  <= bus.i_addr;
        memWdata <= '0;
        memWstrb <= '0;
        tmoCnt   <= '0;
      end else if (dWin) begin
        memReq   <= 1'b1;
        memWe    <= bus.d_we;
        memAddr  <= bus.d_addr;
        memWdata <= bus.d_wdata;
        memWstrb <= bus.d_we ? bus.d_wstrb : 4'b0000;
        tmoCnt   <= '0;
      end else if (memDone || tmoHit) begin
        memReq <= 1'b0;
        tmoCnt <= '0;
        // An aborted fetch returns a NOP so the pipeline keeps moving
        if (stateQ == BUSY_I) begin
          iRvalid <= 1'b1;
          iRdata  <= memDone ? bus.mem_rdata : NOP;
        end else begin
          dRvalid <= 1'b1;
          dRdata  <= (memDone && !memWe) ? bus.mem_rdata : '0;
        end
      end else if (stateQ != IDLE) begin
        tmoCnt <= tmoCnt + TW'(1);
      end

      if (iWin)
        starveCnt <= '0;
      else if (dWin && bus.i_req && !starved)
        starveCnt <= starveCnt + SW'(1);

      if (tmoHit)
        errQ <= 1'b1;
      else if (bus.err_clr)
        errQ <= 1'b0;
    end
  end

  assign bus.i_gnt     = iWin;
  assign bus.d_gnt     = dWin;
  assign bus.i_rvalid  = iRvalid;
  assign bus.i_rdata   = iRdata;
  assign bus.d_rvalid  = dRvalid;
  assign bus.d_rdata   = dRdata;
  assign bus.stall_f   = bus.i_req & ~iRvalid;
  assign bus.stall_m   = bus.d_req & ~dRvalid;
  assign bus.mem_req   = memReq;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.mem_wstrb = memWstrb;
  assign bus.err       = errQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected memory
// transactions and responses; a memory model and a monitor pop and compare.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          lat;
    bit          hang;
  } memEnt_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    bit isD;
    int cyc;
  } gnt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  memEnt_t memQ[$];
  rsp_t    iExpQ[$];
  rsp_t    dExpQ[$];
  gnt_t    gntLog[$];
  int      memStartCyc = -1;
  int      lastIRvCyc = -1;
  int      lastDRvCyc = -1;
  bit      spurReady = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: answers each access after its scripted latency
  initial begin : memModel
    memEnt_t cur;
    bit prevReq;
    bit active;
    int idx;
    prevReq = 1'b0;
    active = 1'b0;
    idx = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (!rst) begin
        prevReq = 1'b0;
        active = 1'b0;
        continue;
      end
      if (bus.mem_req && !prevReq) begin
        memStartCyc = cyc;
        if (memQ.size() == 0) begin
          chk("mem_unexpected_access", bus.mem_addr, 32'hFFFF_FFFF);
          active = 1'b0;
        end else begin
          cur = memQ.pop_front();
          active = 1'b1;
          idx = 0;
          chk("mem_addr", bus.mem_addr, cur.addr);
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, cur.we});
          chk("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, cur.wstrb});
          if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
        end
      end
      if (bus.mem_req && active) begin
        idx++;
        if (idx > 1) chk("mem_addr_hold", bus.mem_addr, cur.addr);
        if (!cur.hang && idx == cur.lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = cur.rdata;
        end
      end else if (spurReady && !bus.mem_req) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
      end
      prevReq = bus.mem_req;
    end
  end

  // Monitor: grants, stalls and completions
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.i_gnt || bus.d_gnt) begin
          chk("gnt_exclusive", {31'd0, bus.i_gnt & bus.d_gnt}, 32'd0);
          chk("gnt_outside_idle", {31'd0, bus.mem_req}, 32'd0);
          gntLog.push_back('{isD: bus.d_gnt, cyc: cyc});
        end
        if (bus.i_req) chk("stall_f", {31'd0, bus.stall_f}, {31'd0, ~bus.i_rvalid});
        if (bus.d_req) chk("stall_m", {31'd0, bus.stall_m}, {31'd0, ~bus.d_rvalid});
        if (bus.i_rvalid) begin
          lastIRvCyc = cyc;
          if (iExpQ.size() == 0) chk("i_rvalid_unexpected", 32'd1, 32'd0);
          else begin
            e = iExpQ.pop_front();
            chk("i_rdata", bus.i_rdata, e.data);
            chk("i_err", {31'd0, bus.err}, {31'd0, e.err});
          end
        end
        if (bus.d_rvalid) begin
          lastDRvCyc = cyc;
          if (dExpQ.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
          else begin
            e = dExpQ.pop_front();
            chk("d_rdata", bus.d_rdata, e.data);
            chk("d_err", {31'd0, bus.err}, {31'd0, e.err});
          end
        end
      end
    end
  end

  task automatic iAccess(input logic [31:0] addr, input bit hold);
    int n;
    n = 0;
    bus.i_req = 1'b1;
    bus.i_addr = addr;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.i_gnt && n < 300);
    chk("i_gnt_wait", {31'd0, bus.i_gnt}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) bus.i_req = 1'b0;
  endtask

  task automatic dAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input bit hold);
    int n;
    n = 0;
    bus.d_req = 1'b1;
    bus.d_we = we;
    bus.d_addr = addr;
    bus.d_wdata = wdata;
    bus.d_wstrb = wstrb;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.d_gnt && n < 300);
    chk("d_gnt_wait", {31'd0, bus.d_gnt}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) bus.d_req = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((iExpQ.size() != 0 || dExpQ.size() != 0 || bus.mem_req) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", iExpQ.size() + dExpQ.size() + {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic memEnt_t rd(input logic [31:0] a, input logic [31:0] d, input int lat);
    return '{addr: a, we: 1'b0, wdata: '0, wstrb: 4'b0000, rdata: d, lat: lat, hang: 1'b0};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    memEnt_t m;
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.d_wstrb = '0;
    bus.err_clr = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_rvalid", {30'd0, bus.i_rvalid, bus.d_rvalid}, 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: I-only read, memory answers in the third BUSY cycle
    gntLog.delete();
    memQ.push_back(rd(32'h100, 32'h0050_0093, 3));
    iExpQ.push_back('{data: 32'h0050_0093, err: 1'b0});
    iAccess(32'h100, 1'b0);
    waitDrain();
    chk("t1_gnt_count", gntLog.size(), 32'd1);
    if (gntLog.size() >= 1) begin
      chk("t1_gnt_is_i", {31'd0, gntLog[0].isD}, 32'd0);
      chk("t1_mem_req_start", memStartCyc, gntLog[0].cyc + 1);
      chk("t1_rvalid_cycle", lastIRvCyc, gntLog[0].cyc + 4);
    end

    // 2: simultaneous requests, D wins, I granted in D's rvalid cycle
    gntLog.delete();
    memQ.push_back(rd(32'h2000, 32'hCAFE_F00D, 2));
    memQ.push_back(rd(32'h300, 32'h0000_0033, 1));
    dExpQ.push_back('{data: 32'hCAFE_F00D, err: 1'b0});
    iExpQ.push_back('{data: 32'h0000_0033, err: 1'b0});
    fork
      iAccess(32'h300, 1'b0);
      dAccess(1'b0, 32'h2000, 32'h0, 4'b0000, 1'b0);
    join
    waitDrain();
    chk("t2_gnt_count", gntLog.size(), 32'd2);
    if (gntLog.size() >= 2) begin
      chk("t2_first_is_d", {31'd0, gntLog[0].isD}, 32'd1);
      chk("t2_second_is_i", {31'd0, gntLog[1].isD}, 32'd0);
      chk("t2_i_gnt_at_d_rvalid", gntLog[1].cyc, lastDRvCyc);
      chk("t2_min_latency", lastIRvCyc, gntLog[1].cyc + 2);
    end

    // 3: D held back-to-back, I held: four D wins then I is forced through
    gntLog.delete();
    for (int k = 0; k < 4; k++) begin
      memQ.push_back(rd(32'h3000 + 32'(4 * k), 32'h1000 + 32'(k), 1));
      dExpQ.push_back('{data: 32'h1000 + 32'(k), err: 1'b0});
    end
    memQ.push_back(rd(32'h500, 32'h0000_0513, 1));
    iExpQ.push_back('{data: 32'h0000_0513, err: 1'b0});
    for (int k = 4; k < 6; k++) begin
      memQ.push_back(rd(32'h3000 + 32'(4 * k), 32'h1000 + 32'(k), 1));
      dExpQ.push_back('{data: 32'h1000 + 32'(k), err: 1'b0});
    end
    fork
      iAccess(32'h500, 1'b0);
      begin
        for (int k = 0; k < 6; k++)
          dAccess(1'b0, 32'h3000 + 32'(4 * k), 32'h0, 4'b0000, k < 5);
      end
    join
    waitDrain();
    chk("t3_gnt_count", gntLog.size(), 32'd7);
    for (int k = 0; k < 7 && k < gntLog.size(); k++)
      chk("t3_gnt_order", {31'd0, gntLog[k].isD}, (k == 4) ? 32'd0 : 32'd1);
    chk("t3_starve_cleared", 32'(dut.starveCnt), 32'd0);

    // 4: store returns zero data
    memQ.push_back('{addr: 32'h40, we: 1'b1, wdata: 32'hDEAD_BEEF, wstrb: 4'b0011,
                     rdata: 32'hFFFF_FFFF, lat: 2, hang: 1'b0});
    dExpQ.push_back('{data: 32'h0, err: 1'b0});
    dAccess(1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011, 1'b0);
    waitDrain();

    // mem_ready while IDLE must be ignored
    spurReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spurReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("spur_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("spur_no_err", {31'd0, bus.err}, 32'd0);

    // mem_ready on the last BUSY cycle before timeout: completes normally
    memQ.push_back(rd(32'h104, 32'h00A0_0113, 64));
    iExpQ.push_back('{data: 32'h00A0_0113, err: 1'b0});
    iAccess(32'h104, 1'b0);
    waitDrain();
    chk("t5_ready_beats_timeout_err", {31'd0, bus.err}, 32'd0);

    // 5: hung fetch times out to a NOP, err is sticky until cleared
    m = rd(32'h200, 32'h0, 0);
    m.hang = 1'b1;
    memQ.push_back(m);
    iExpQ.push_back('{data: 32'h0000_0013, err: 1'b1});
    iAccess(32'h200, 1'b0);
    waitDrain();
    chk("t5_timeout_cycles", lastIRvCyc - memStartCyc, 32'd64);
    memQ.push_back(rd(32'h2004, 32'h1234_5678, 2));
    dExpQ.push_back('{data: 32'h1234_5678, err: 1'b1});
    dAccess(1'b0, 32'h2004, 32'h0, 4'b0000, 1'b0);
    waitDrain();
    chk("t5_err_sticky", {31'd0, bus.err}, 32'd1);
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    chk("t5_err_cleared", {31'd0, bus.err}, 32'd0);

    // hung D access with err_clr held: timeout wins, err is 1 at rvalid, cleared after
    m = rd(32'h2010, 32'h0, 0);
    m.hang = 1'b1;
    memQ.push_back(m);
    dExpQ.push_back('{data: 32'h0, err: 1'b1});
    bus.err_clr = 1'b1;
    dAccess(1'b0, 32'h2010, 32'h0, 4'b0000, 1'b0);
    waitDrain();
    bus.err_clr = 1'b0;
    chk("t5_err_clr_after_timeout", {31'd0, bus.err}, 32'd0);

    // 6: reset in the 2nd BUSY_D cycle drops the access without rvalid
    memQ.push_back(rd(32'h2008, 32'h5555_AAAA, 10));
    dAccess(1'b0, 32'h2008, 32'h0, 4'b0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_mem_req_dropped", {31'd0, bus.mem_req}, 32'd0);
    chk("t6_no_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    gntLog.delete();
    memQ.push_back(rd(32'h108, 32'h0010_0073, 2));
    iExpQ.push_back('{data: 32'h0010_0073, err: 1'b0});
    iAccess(32'h108, 1'b0);
    waitDrain();
    chk("t6_regrant", gntLog.size(), 32'd1);
    chk("t6_memq_empty", memQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (I port, read-only) and the memory stage (D port, read/write) of the RV32I 5-stage pipeline.
- Arbitrates between the two ports and sequences each access over a variable-latency memory handshake.
- Produces stall requests for both stages.
- Adds anti-starvation for fetch and a sticky timeout error for a hung memory.

Parameters:
- STARVE_LIMIT, 4: consecutive contested arbitrations lost by I before I is forced to win.
- TIMEOUT, 64: BUSY cycles without mem_ready before the access is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  32  fetch byte address (word-aligned)
- i_gnt  out  1  fetch request accepted (combinational, IDLE only)
- i_rvalid  out  1  one-cycle fetch completion pulse
- i_rdata  out  32  fetched instruction, valid with i_rvalid
- d_req  in  1  data request; held with d_* stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  one-cycle data completion pulse (loads and stores)
- d_rdata  out  32  load data; 0 for stores
- stall_f  out  1  i_req & ~i_rvalid
- stall_m  out  1  d_req & ~d_rvalid
- mem_req  out  1  memory access active; held until mem_ready
- mem_we  out  1  memory write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables; 0000 for reads
- mem_rdata  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle access completion
- err  out  1  sticky timeout flag
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (rst=0, asynchronous, also mid-access):
  - State goes to IDLE.
  - mem_req, mem_we, mem_wstrb, i_rvalid, d_rvalid, err, starve_cnt and tmo_cnt are all 0.
  - mem_addr, mem_wdata, i_rdata and d_rdata are 0.
  - An in-flight access is dropped; no rvalid is produced.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration:
  - Only one request present: that requester wins.
  - Both requests present: D wins, unless starve_cnt == STARVE_LIMIT, in which case I wins.
  - The winner's gnt is high in the same cycle.
  - On the next edge: state becomes BUSY_x; mem_req=1; mem_addr, mem_we, mem_wdata and mem_wstrb are registered from the winner (I port: we=0, wstrb=0000).
- starve_cnt:
  - +1 on each contested arbitration won by D, saturating at STARVE_LIMIT.
  - Cleared whenever I is granted.
- BUSY_x:
  - mem_* outputs are held stable; tmo_cnt +1 per cycle.
  - On mem_ready=1:
    - The owner's rvalid pulses for 1 cycle on the next cycle.
    - rdata is registered from mem_rdata; D stores return 0.
    - mem_req drops, state returns to IDLE, tmo_cnt clears.
  - When tmo_cnt reaches TIMEOUT-1 with mem_ready=0 (the TIMEOUT-th BUSY cycle):
    - The access is aborted and err set to 1.
    - rvalid pulses with i_rdata = 32'h0000_0013 (NOP) for I, or d_rdata = 0 for D.
    - State returns to IDLE.
  - mem_ready and timeout in the same cycle: mem_ready wins and err is unchanged.
- mem_ready in IDLE is ignored.
- Latency:
  - gnt in cycle N; mem_req from N+1.
  - mem_ready at cycle k gives rvalid at k+1; state is IDLE at k+1, so a new gnt is possible at k+1.
  - Minimum access: gnt to rvalid = 2 cycles.
- Requests are not retracted before gnt; a retraction is undefined for the bench.
- err_clr=1 clears err on the next edge; a simultaneous timeout wins (err stays 1).
- gnt is never asserted outside IDLE; i_gnt and d_gnt are never both 1.

Test Plan:
1. I-only read of 0x100, mem_ready 2 cycles after mem_req rises, mem_rdata=0x00500093 -> i_gnt at cycle 0; mem_req cycles 1–3 with mem_addr=0x100, mem_we=0; i_rvalid at cycle 4 with i_rdata=0x00500093; stall_f=1 in cycles 0–3.
2. i_req and d_req rise together, load from 0x2000 -> d_gnt first, d_rvalid with data; i_gnt in the same cycle as d_rvalid; i_rvalid follows.
3. d_req held continuously with back-to-back D accesses, i_req held, STARVE_LIMIT=4 -> D wins 4 contested arbitrations, I wins the 5th, starve_cnt returns to 0.
4. Store d_addr=0x40, d_wdata=0xDEADBEEF, d_wstrb=0011 -> mem_we=1, mem_wstrb=0011, mem_wdata=0xDEADBEEF; d_rvalid=1 with d_rdata=0.
5. I access with mem_ready never asserted -> after 64 BUSY cycles, i_rvalid with i_rdata=0x00000013 and err=1; err stays 1 through later accesses; err_clr=1 clears it next cycle.
6. rst=0 asserted during the 2nd cycle of BUSY_D -> mem_req drops immediately with no d_rvalid; after release a new I request is granted from IDLE.
